ita_dequantizer: RTL and testbench

- Inverse-direction companion of the output requantizer: expands N-lane WI-bit quantized activations back into the WO-bit accumulator domain.
- Per lane, computes saturate_WO(((mult_eps × x) <<< left_shift) + bias).
- Sits between the activation buffer and the accumulator/softmax path.
- Elastic 2-stage valid/ready pipeline; per-beat constants travel with the data.

---
 rtl/ita_dequantizer_pkg.sv | 29 ++
 rtl/ita_dequantizer_lane.sv | 58 +++++
 rtl/ita_dequantizer.sv | 93 +++++++++
 tb/tb_ita_dequantizer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ita_dequantizer_pkg.sv
// Shared widths and types for the dequantizer slice.
// Lanes are packed with lane 0 in the least-significant bits.
package ita_package;

  localparam int N    = 16;
  localparam int WI   = 8;
  localparam int WO   = 26;
  localparam int EMS  = 8;
  localparam int WS   = 5;

  // exact product width and overflow-free shift/add width
  localparam int PW   = EMS + WI + 2;
  localparam int WINT = WO + EMS + WI + (2 ** WS);

  typedef enum logic {
    SIGNED   = 1'b0,
    UNSIGNED = 1'b1
  } dequant_mode_e;

  typedef logic [N-1:0][WI-1:0] dequant_inp_t;
  typedef logic [N-1:0][WO-1:0] dequant_oup_t;
  typedef logic [N-1:0][WO-1:0] bias_t;
  typedef logic [EMS-1:0]       dequant_const_t;
  typedef logic [WS-1:0]        shift_t;

  typedef logic signed [PW-1:0] prod_t;
  typedef logic [N-1:0][PW-1:0] prod_vec_t;

endpackage

// File: rtl/ita_dequantizer_lane.sv
// One dequant lane: extend+multiply (stage 1 input side) and
// shift/add/saturate (stage 2 input side), both combinational.
// mode_i/eps_i/x_i -> prod_o ; prod_i/shift_i/bias_i -> oup_o/sat_o.
module ita_dequant_lane
  import ita_package::*;
(
  input  dequant_mode_e  mode_i,
  input  dequant_const_t eps_i,
  input  logic [WI-1:0]  x_i,
  output prod_t          prod_o,
  input  prod_t          prod_i,
  input  shift_t         shift_i,
  input  logic [WO-1:0]  bias_i,
  output logic [WO-1:0]  oup_o,
  output logic           sat_o
);

  logic signed [WI:0]  ext;
  logic signed [EMS:0] eps_s;
  prod_t               ext_w;
  prod_t               eps_w;

  always_comb begin
    ext = (mode_i == UNSIGNED) ? {1'b0, x_i}
                               : {x_i[WI-1], x_i};
    eps_s = {1'b0, eps_i};
    ext_w = PW'(ext);
    eps_w = PW'(eps_s);
  end

  assign prod_o = eps_w * ext_w;

  logic signed [WINT-1:0] prod_x;
  logic signed [WINT-1:0] bias_x;
  logic signed [WINT-1:0] wide;
  logic                   hi_ones;
  logic                   hi_zeros;

  always_comb begin
    prod_x = WINT'(prod_i);
    bias_x = WINT'($signed(bias_i));
    wide   = (prod_x <<< shift_i) + bias_x;
  end

  // in range iff every bit above the output sign bit copies it
  assign hi_ones  = &wide[WINT-1:WO-1];
  assign hi_zeros = ~|wide[WINT-1:WO-1];

  always_comb begin
    sat_o = !(hi_ones || hi_zeros);
    oup_o = wide[WO-1:0];
    if (sat_o) begin
      oup_o = wide[WINT-1] ? {1'b1, {(WO-1){1'b0}}}
                           : {1'b0, {(WO-1){1'b1}}};
    end
  end

endmodule

// File: rtl/ita_dequantizer.sv
// N-lane dequantizer: sat(((eps*x) <<< shift) + bias), 2-stage valid/ready.
// In: valid_i/mode/eps/shift/inp/bias/last; out: valid_o/oup/sat/last.
module ita_dequantizer
  import ita_package::*;
(
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic           mode_i,
  input  dequant_const_t eps_mult_i,
  input  shift_t         left_shift_i,
  input  dequant_inp_t   inp_i,
  input  bias_t          bias_i,
  input  logic           last_i,
  output logic           valid_o,
  input  logic           ready_i,
  output dequant_oup_t   oup_o,
  output logic [N-1:0]   sat_o,
  output logic           last_o
);

  logic s1_valid;
  logic s2_valid;
  logic s1_adv;
  logic s2_adv;
  logic acc;

  prod_vec_t s1_prod;
  bias_t     s1_bias;
  shift_t    s1_shift;
  logic      s1_last;

  prod_vec_t    prod_d;
  dequant_oup_t oup_d;
  logic [N-1:0] sat_d;

  assign s2_adv  = !s2_valid || ready_i;
  assign s1_adv  = s1_valid && s2_adv;
  assign ready_o = !s1_valid || s2_adv;
  assign acc     = valid_i && ready_o;

  for (genvar g = 0; g < N; g++) begin : g_lane
    ita_dequant_lane u_lane (
      .mode_i  (dequant_mode_e'(mode_i)),
      .eps_i   (eps_mult_i),
      .x_i     (inp_i[g]),
      .prod_o  (prod_d[g]),
      .prod_i  (s1_prod[g]),
      .shift_i (s1_shift),
      .bias_i  (s1_bias[g]),
      .oup_o   (oup_d[g]),
      .sat_o   (sat_d[g])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_bias  <= '0;
      s1_shift <= '0;
      s1_last  <= 1'b0;
    end else if (ready_o) begin
      s1_valid <= acc;
      if (acc) begin
        s1_prod  <= prod_d;
        s1_bias  <= bias_i;
        s1_shift <= left_shift_i;
        s1_last  <= last_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      oup_o    <= '0;
      sat_o    <= '0;
      last_o   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_adv;
      if (s1_adv) begin
        oup_o  <= oup_d;
        sat_o  <= sat_d;
        last_o <= s1_last;
      end
    end
  end

  assign valid_o = s2_valid;

endmodule

// File: tb/tb_ita_dequantizer.sv
// Scoreboard bench for ita_dequantizer: directed beats, queued
// expectations, negedge monitor comparing every consumed beat.
module tb_ita_dequantizer;
  import ita_package::*;

  localparam int NW = N * WO;
  localparam longint MAXV = (64'sd1 <<< (WO - 1)) - 1;
  localparam longint MINV = -MAXV - 1;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              valid_i;
  logic              ready_o;
  logic              mode_i;
  logic [EMS-1:0]    eps_mult_i;
  logic [WS-1:0]     left_shift_i;
  logic [N*WI-1:0]   inp_i;
  logic [NW-1:0]     bias_i;
  logic              last_i;
  logic              valid_o;
  logic              ready_i;
  logic [NW-1:0]     oup_o;
  logic [N-1:0]      sat_o;
  logic              last_o;

  ita_dequantizer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .mode_i       (mode_i),
    .eps_mult_i   (eps_mult_i),
    .left_shift_i (left_shift_i),
    .inp_i        (inp_i),
    .bias_i       (bias_i),
    .last_i       (last_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .oup_o        (oup_o),
    .sat_o        (sat_o),
    .last_o       (last_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  typedef struct {
    logic [NW-1:0] oup;
    logic [N-1:0]  sat;
    logic          last;
    int            acc_cyc;
    bit            chk_lat;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [NW-1:0] a,
                     input logic [NW-1:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, a, x);
    end
  endtask

  // lane k gets bias0+k; its unclamped result is exp0+k
  task automatic send(input bit m, input int eps, input int sh,
                      input int x, input longint bias0,
                      input longint exp0, input bit last,
                      input bit push, input bit lat);
    logic [N*WI-1:0] inp;
    logic [NW-1:0]   b;
    logic [NW-1:0]   eo;
    logic [N-1:0]    es;
    longint          v;
    exp_t            e;
    bit              got;
    int              n;
    for (int k = 0; k < N; k++) begin
      inp[k*WI +: WI] = WI'(x);
      b[k*WO +: WO]   = WO'(bias0 + longint'(k));
      v     = exp0 + longint'(k);
      es[k] = 1'b0;
      if (v > MAXV) begin v = MAXV; es[k] = 1'b1; end
      if (v < MINV) begin v = MINV; es[k] = 1'b1; end
      eo[k*WO +: WO] = WO'(v);
    end
    mode_i       = m;
    eps_mult_i   = EMS'(eps);
    left_shift_i = WS'(sh);
    inp_i        = inp;
    bias_i       = b;
    last_i       = last;
    valid_i      = 1'b1;
    got = 0;
    n   = 0;
    while (!got && n < 50) begin
      @(negedge clk_i);
      if (ready_o) begin
        got = 1;
        if (push) begin
          e.oup     = eo;
          e.sat     = es;
          e.last    = last;
          e.acc_cyc = cyc;
          e.chk_lat = lat;
          sb.push_back(e);
        end
      end
      @(posedge clk_i);
      #1;
      n++;
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got=stuck want=accepted");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    chk("drain_left", NW'(sb.size()), NW'(0));
  endtask

  exp_t          me;
  bit            prev_stall = 0;
  logic [NW-1:0] prev_oup;
  logic [N-1:0]  prev_sat;
  logic          prev_last;

  always @(negedge clk_i) begin
    if (prev_stall && valid_o && !rst_i) begin
      chk("stall_oup", oup_o, prev_oup);
      chk("stall_sat", NW'(sat_o), NW'(prev_sat));
      chk("stall_last", NW'(last_o), NW'(prev_last));
    end
    if (valid_o && ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat got=%0h want=none", oup_o);
      end else begin
        me = sb.pop_front();
        chk("oup", oup_o, me.oup);
        chk("sat", NW'(sat_o), NW'(me.sat));
        chk("last", NW'(last_o), NW'(me.last));
        if (me.chk_lat)
          chk("latency", NW'(cyc - me.acc_cyc), NW'(2));
      end
    end
    prev_stall = valid_o && !ready_i;
    prev_oup   = oup_o;
    prev_sat   = sat_o;
    prev_last  = last_o;
  end

  initial begin
    rst_i        = 1'b1;
    valid_i      = 1'b0;
    ready_i      = 1'b1;
    mode_i       = 1'b0;
    eps_mult_i   = '0;
    left_shift_i = '0;
    inp_i        = '0;
    bias_i       = '0;
    last_i       = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rst_valid", NW'(valid_o), NW'(0));
    chk("rst_ready", NW'(ready_o), NW'(1));
    chk("rst_oup", oup_o, NW'(0));
    chk("rst_sat", NW'(sat_o), NW'(0));
    chk("rst_last", NW'(last_o), NW'(0));
    @(posedge clk_i);
    #1;

    send(0, 5, 2, -3, 7, -53, 0, 1, 1);
    send(1, 1, 0, 255, 0, 255, 0, 1, 1);
    send(0, 1, 0, 255, 0, -1, 0, 1, 1);
    send(0, 255, 20, 127, 0, 64'sd33958133760, 0, 1, 1);
    send(0, 255, 20, -128, 0, -64'sd34225520640, 0, 1, 1);
    send(0, 255, 31, -1, 0, -64'sd547608330240, 0, 1, 1);
    send(0, 1, 24, 1, 0, 16777216, 0, 1, 1);
    send(0, 1, 25, 1, 0, 33554432, 0, 1, 1);
    send(0, 0, 7, 100, -5, -5, 0, 1, 1);
    send(1, 0, 3, 200, MAXV - 15, MAXV - 15, 0, 1, 1);
    send(0, 1, 0, 15, MAXV - 15, MAXV, 0, 1, 1);
    send(0, 1, 0, -1, MINV, MINV - 1, 0, 1, 1);
    send(1, 255, 0, 255, 0, 65025, 1, 1, 1);
    drain();

    fork
      begin
        send(0, 3, 1, 10, 0, 60, 0, 1, 0);
        send(0, 3, 1, -10, 0, -60, 0, 1, 0);
        send(1, 2, 4, 250, 100, 8100, 0, 1, 0);
        send(0, 1, 0, -128, 0, -128, 1, 1, 0);
      end
      begin
        ready_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        chk("bp_ready_low", NW'(ready_o), NW'(0));
        ready_i = 1'b1;
      end
    join
    drain();

    ready_i = 1'b0;
    send(0, 1, 0, 1, 0, 1, 0, 0, 0);
    send(0, 1, 0, 2, 0, 2, 0, 0, 0);
    chk("pre_rst_valid", NW'(valid_o), NW'(1));
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("flush_valid", NW'(valid_o), NW'(0));
    chk("flush_oup", oup_o, NW'(0));
    chk("flush_ready", NW'(ready_o), NW'(1));
    ready_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    chk("final_queue", NW'(sb.size()), NW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
